// File: rtl/seq_cpu_pkg.sv
// Shared types and constants for the accumulator CPU and its program memory model.
// Holds the default datapath width, the word type, the opcode enum and the
// sub-codes used by the 0xE I/O instruction group.
package seq_cpu_pkg;

    parameter int BITNESS = 16;

    typedef logic [BITNESS-1:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDN  = 4'h1,
        OP_STR  = 4'h2,
        OP_LDR  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_BZ   = 4'hB,
        OP_BNZ  = 4'hC,
        OP_JR   = 4'hD,
        OP_IO   = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    localparam logic [3:0] IO_IN  = 4'h0;
    localparam logic [3:0] IO_OUT = 4'h1;

endpackage

// File: rtl/seq_cpu_test_mem.sv
// Byte-wide preloadable program ROM for benches; array m is filled hierarchically.
// Latency: combinational read, read = m[addr]; out-of-range addresses read 0.
// Backpressure: none; write data and clock are accepted but have no effect.
// Ports: clk, addr (byte address), write (ignored), read (instruction byte).
module test_mem
    import seq_cpu_pkg::*;
#(
    parameter int BITNESS   = seq_cpu_pkg::BITNESS,
    parameter int MEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic [BITNESS-1:0] addr,
    input  logic [7:0]         write,
    output logic [7:0]         read
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] m [0:MEM_BYTES-1];

    // The memory is a ROM: the write port and clock exist only for interface shape.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, write};

    logic [63:0] addr_ext;
    assign addr_ext = 64'(addr);

    always_comb begin
        read = 8'h00;
        if (addr_ext < 64'(MEM_BYTES)) begin
            read = m[addr_ext[AW-1:0]];
        end
    end

endmodule

// File: rtl/seq_cpu.sv
// Single-cycle accumulator CPU: fetch byte at pc, decode/execute, commit on clk.
// Latency: one instruction per cycle; pin_out updates right after the OUT edge.
// Backpressure: none; HALT freezes all state until asynchronous reset (rst low).
// Ports: clk, rst (active-low async), m_addr/m_read (fetch), pin_in, pin_out, pc.
module seq_cpu
    import seq_cpu_pkg::*;
#(
    parameter int BITNESS = seq_cpu_pkg::BITNESS
) (
    input  logic               clk,
    input  logic               rst,
    output logic [BITNESS-1:0] m_addr,
    input  logic [7:0]         m_read,
    input  logic [BITNESS-1:0] pin_in,
    output logic [BITNESS-1:0] pin_out,
    output logic [BITNESS-1:0] pc
);

    logic [BITNESS-1:0] acc;
    logic [BITNESS-1:0] regs [4];
    logic [BITNESS-1:0] pc_q;
    logic [BITNESS-1:0] pin_out_q;
    logic               halted;

    logic [BITNESS-1:0] acc_d;
    logic [BITNESS-1:0] pc_d;
    logic [BITNESS-1:0] pin_out_d;
    logic               halted_d;
    logic               reg_we;

    op_e                op;
    logic [3:0]         n;
    logic [1:0]         ridx;
    logic [BITNESS-1:0] rval;
    logic [BITNESS-1:0] pc_inc;
    logic [BITNESS-1:0] pc_br;

    assign op     = op_e'(m_read[7:4]);
    assign n      = m_read[3:0];
    assign ridx   = n[1:0];
    assign rval   = regs[ridx];
    assign pc_inc = pc_q + BITNESS'(1);
    // Branch target is relative to the following instruction, offset sign-extended.
    assign pc_br  = pc_inc + {{(BITNESS-4){n[3]}}, n};

    assign m_addr  = pc_q;
    assign pc      = pc_q;
    assign pin_out = pin_out_q;

    always_comb begin
        acc_d     = acc;
        pc_d      = pc_inc;
        pin_out_d = pin_out_q;
        halted_d  = halted;
        reg_we    = 1'b0;
        if (halted) begin
            pc_d = pc_q;
        end else begin
            unique case (op)
                OP_NOP:  ;
                OP_LDN:  acc_d = {acc[BITNESS-5:0], n};
                OP_STR:  reg_we = 1'b1;
                OP_LDR:  acc_d = rval;
                OP_ADD:  acc_d = acc + rval;
                OP_SUB:  acc_d = acc - rval;
                OP_AND:  acc_d = acc & rval;
                OP_OR:   acc_d = acc | rval;
                OP_XOR:  acc_d = acc ^ rval;
                OP_SHL:  acc_d = acc << n;
                OP_SHR:  acc_d = acc >> n;
                OP_BZ:   if (acc == '0) pc_d = pc_br;
                OP_BNZ:  if (acc != '0) pc_d = pc_br;
                OP_JR:   pc_d = rval;
                OP_IO: begin
                    if (n == IO_IN)  acc_d     = pin_in;
                    if (n == IO_OUT) pin_out_d = acc;
                end
                OP_HALT: begin
                    // Halt parks pc on the HALT byte so it reads as the stop point.
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            pc_q      <= '0;
            pin_out_q <= '0;
            halted    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            acc       <= acc_d;
            pc_q      <= pc_d;
            pin_out_q <= pin_out_d;
            halted    <= halted_d;
            if (reg_we) begin
                regs[ridx] <= acc;
            end
        end
    end

endmodule

// File: tb/tb_seq_cpu.sv
module tb_seq_cpu;
    import seq_cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] m_addr;
    logic [7:0]  m_read;
    logic [15:0] pin_in;
    logic [15:0] pin_out;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    logic [7:0] prog [$];

    seq_cpu #(.BITNESS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_addr  (m_addr),
        .m_read  (m_read),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pc      (pc)
    );

    test_mem #(.BITNESS(16), .MEM_BYTES(1024)) mem (
        .clk   (clk),
        .addr  (m_addr),
        .write (8'h00),
        .read  (m_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold reset, load the current prog queue at address 0 (rest NOP), release at a negedge.
    task automatic start_prog();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) mem.m[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) mem.m[i] = prog[i];
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input int edges);
        repeat (edges) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        pin_in = 16'h0000;
        #12;
        check("reset_pc", pc, 16'h0000);
        check("reset_m_addr", m_addr, 16'h0000);
        check("reset_pin_out", pin_out, 16'h0000);

        // Character output: A = 0x121, strobe set, char 'H'.
        prog = '{8'h11, 8'h12, 8'h11, 8'hE1};
        start_prog();
        step(4);
        check("ldn_acc", dut.acc, 16'h0121);
        check("out_pin", pin_out, 16'h0121);
        check("out_strobe", {15'd0, pin_out[0]}, 16'h0001);
        check("out_char", {8'd0, pin_out[9:2]}, 16'h0048);
        check("out_pc", pc, 16'h0004);

        // Halt holds pc and pins; reset while halted clears immediately.
        prog = '{8'h12, 8'hE1, 8'hF0, 8'h00};
        start_prog();
        step(2);
        check("halt_out", pin_out, 16'h0002);
        check("halt_pc_e2", pc, 16'h0002);
        step(11);
        check("halt_pc_hold", pc, 16'h0002);
        check("halt_out_hold", pin_out, 16'h0002);
        #2 rst = 1'b0;
        #1;
        check("halt_rst_pc", pc, 16'h0000);
        check("halt_rst_out", pin_out, 16'h0000);

        // BZ taken skips both 1F bytes.
        prog = '{8'h10, 8'hB2, 8'h1F, 8'h1F, 8'hE1};
        start_prog();
        step(2);
        check("bz_pc", pc, 16'h0004);
        step(1);
        check("bz_out", pin_out, 16'h0000);
        check("bz_acc", dut.acc, 16'h0000);

        // BNZ taken with A = 1.
        prog = '{8'h11, 8'hC2, 8'h1F, 8'h1F, 8'hE1};
        start_prog();
        step(2);
        check("bnz_pc", pc, 16'h0004);
        step(1);
        check("bnz_out", pin_out, 16'h0001);

        // IN / STR / ADD / OUT, then wraparound add.
        prog = '{8'hE0, 8'h20, 8'h40, 8'hE1, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h40, 8'hE1, 8'hF0};
        pin_in = 16'h0001;
        start_prog();
        step(1);
        pin_in = 16'h0BAD;
        step(3);
        check("in_out", pin_out, 16'h0002);
        step(4);
        check("ffff_acc", dut.acc, 16'hFFFF);
        step(1);
        check("wrap_acc", dut.acc, 16'h0000);
        step(1);
        check("wrap_out", pin_out, 16'h0000);
        pin_in = 16'h0000;

        // JR through R1.
        prog = '{8'h13, 8'h21, 8'hD1};
        start_prog();
        #1;
        check("jr_pc0", pc, 16'h0000);
        step(1);
        check("jr_pc1", pc, 16'h0001);
        step(1);
        check("jr_pc2", pc, 16'h0002);
        step(1);
        check("jr_pc3", pc, 16'h0003);

        // Logic / shift chain: 5C|5=5D, ^5=58, -5=53, <<4=530, >>2=14C, &5=4.
        prog = '{8'h15, 8'h21, 8'h1C, 8'h71, 8'h81, 8'h51, 8'h94, 8'hA2, 8'h61, 8'hE1};
        start_prog();
        step(4);
        check("or_acc", dut.acc, 16'h005D);
        step(1);
        check("xor_acc", dut.acc, 16'h0058);
        step(1);
        check("sub_acc", dut.acc, 16'h0053);
        step(1);
        check("shl_acc", dut.acc, 16'h0530);
        step(1);
        check("shr_acc", dut.acc, 16'h014C);
        step(2);
        check("and_out", pin_out, 16'h0004);

        // Counting loop; async reset mid-run, then identical re-run.
        prog = '{8'h11, 8'h20, 8'h40, 8'hE1, 8'hCD};
        start_prog();
        step(10);
        check("loop_pc", pc, 16'h0004);
        check("loop_out", pin_out, 16'h0004);
        #2 rst = 1'b0;
        #1;
        check("loop_rst_pc", pc, 16'h0000);
        check("loop_rst_out", pin_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        step(10);
        check("rerun_pc", pc, 16'h0004);
        check("rerun_out", pin_out, 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
